// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong pixel pipeline: screen geometry defaults,
// the 3-bit colour type, the default background colour and the box_drawer
// state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package pong_pkg;

    // Visible frame-buffer geometry.
    localparam logic [8:0] SCREEN_W = 9'd320;
    localparam logic [8:0] SCREEN_H = 9'd240;

    // One bit per RGB channel.
    typedef logic [2:0] color_t;

    // Colour used to erase a previously drawn box.
    localparam color_t BG_COLOR_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW
    } drawer_state_t;

endpackage

// File: rtl/rect_scanner.sv
// -----------------------------------------------------------------------------
// rect_scanner
// Row-major column/row counter pair walking a BOX_WIDTH x BOX_HEIGHT
// rectangle, one position per advancing cycle. Wraps back to (0,0) after the
// last position so the next phase starts from the origin.
// Ports:
//   clock    in   system clock
//   reset_n  in   synchronous active-low reset
//   clear    in   force both counters to zero
//   advance  in   step to the next position
//   col      out  current column, 0..BOX_WIDTH-1
//   row      out  current row, 0..BOX_HEIGHT-1
//   last     out  current position is the final one of the rectangle
// -----------------------------------------------------------------------------
module rect_scanner #(
    parameter logic [8:0] BOX_WIDTH  = 9'd10,
    parameter logic [8:0] BOX_HEIGHT = 9'd48
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       advance,
    output logic [8:0] col,
    output logic [8:0] row,
    output logic       last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == BOX_WIDTH - 9'd1);
    assign row_end = (row == BOX_HEIGHT - 9'd1);
    assign last    = col_end && row_end;

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            col <= 9'd0;
            row <= 9'd0;
        end else if (advance) begin
            if (col_end) begin
                col <= 9'd0;
                row <= row_end ? 9'd0 : row + 9'd1;
            end else begin
                col <= col + 9'd1;
            end
        end
    end

endmodule

// File: rtl/box_drawer.sv
// -----------------------------------------------------------------------------
// box_drawer
// Pixel stage behind one location processor. Accepts a box position/colour
// over valid/ready, erases the previously drawn box in the background colour
// (optional), then plots the new box one pixel per clock to the VGA adapter.
// Optional feature: define DRAWER_ERASE_EN to enable the erase phase; without
// it every transfer goes straight to drawing and the old box is left behind.
// Ports:
//   clock      in   system clock
//   reset_n    in   synchronous active-low reset
//   m_valid    in   upstream request valid
//   m_ready    out  drawer idle and able to accept a request
//   box_x      in   new box top-left x
//   box_y      in   new box top-left y
//   in_color   in   new box colour
//   vga_x      out  pixel x
//   vga_y      out  pixel y
//   vga_color  out  pixel colour
//   vga_plot   out  write strobe, one pixel per high cycle
// -----------------------------------------------------------------------------
module box_drawer
    import pong_pkg::*;
#(
    parameter logic [8:0] BOX_WIDTH     = 9'd10,
    parameter logic [8:0] BOX_HEIGHT    = 9'd48,
    parameter logic [8:0] SCREEN_WIDTH  = SCREEN_W,
    parameter logic [8:0] SCREEN_HEIGHT = SCREEN_H,
    parameter color_t     BG_COLOR      = BG_COLOR_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       m_valid,
    output logic       m_ready,
    input  logic [8:0] box_x,
    input  logic [8:0] box_y,
    input  logic [2:0] in_color,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_color,
    output logic       vga_plot
);

    drawer_state_t state;

    logic [8:0] new_x;
    logic [8:0] new_y;
    color_t     new_color;

`ifdef DRAWER_ERASE_EN
    logic [8:0] old_x;
    logic [8:0] old_y;
    logic       have_old;
`endif

    logic [8:0] col;
    logic [8:0] row;
    logic       last;
    logic       active;

    assign active  = (state != S_IDLE);
    assign m_ready = !active;

    // Counters sit at the origin while idle and wrap on the last pixel, so
    // they are already cleared on entry to either phase.
    rect_scanner #(
        .BOX_WIDTH (BOX_WIDTH),
        .BOX_HEIGHT(BOX_HEIGHT)
    ) u_scanner (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (!active),
        .advance(active),
        .col    (col),
        .row    (row),
        .last   (last)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            new_x     <= 9'd0;
            new_y     <= 9'd0;
            new_color <= 3'd0;
`ifdef DRAWER_ERASE_EN
            old_x     <= 9'd0;
            old_y     <= 9'd0;
            have_old  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (m_valid) begin
                        new_x     <= box_x;
                        new_y     <= box_y;
                        new_color <= in_color;
`ifdef DRAWER_ERASE_EN
                        state     <= have_old ? S_ERASE : S_DRAW;
`else
                        state     <= S_DRAW;
`endif
                    end
                end
                S_ERASE: begin
                    if (last) state <= S_DRAW;
                end
                S_DRAW: begin
                    if (last) begin
                        state    <= S_IDLE;
`ifdef DRAWER_ERASE_EN
                        old_x    <= new_x;
                        old_y    <= new_y;
                        have_old <= 1'b1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [8:0] base_x;
    logic [8:0] base_y;
    color_t     pix_color;
    logic [9:0] px;
    logic [9:0] py;

    always_comb begin
        base_x    = new_x;
        base_y    = new_y;
        pix_color = new_color;
`ifdef DRAWER_ERASE_EN
        if (state == S_ERASE) begin
            base_x    = old_x;
            base_y    = old_y;
            pix_color = BG_COLOR;
        end
`endif
    end

    // 10-bit sums so boxes hanging past the right/bottom edge are detected
    // instead of wrapping back onto the visible area.
    assign px = {1'b0, base_x} + {1'b0, col};
    assign py = {1'b0, base_y} + {1'b0, row};

    assign vga_plot  = active && (px < {1'b0, SCREEN_WIDTH}) && (py < {1'b0, SCREEN_HEIGHT});
    assign vga_x     = active ? px[8:0] : 9'd0;
    assign vga_y     = active ? py[7:0] : 8'd0;
    // Idle presents the background colour (zero with the default palette).
    assign vga_color = active ? pix_color : BG_COLOR;

endmodule

// File: tb/tb_box_drawer.sv
// -----------------------------------------------------------------------------
// tb_box_drawer
// Directed self-checking bench for box_drawer with a 2x2 box. Expectations
// follow the erase-enabled behaviour when DRAWER_ERASE_EN is defined and the
// draw-only behaviour otherwise.
// -----------------------------------------------------------------------------
module tb_box_drawer;

    localparam int W = 2;
    localparam int H = 2;

    logic       clock;
    logic       reset_n;
    logic       m_valid;
    logic       m_ready;
    logic [8:0] box_x;
    logic [8:0] box_y;
    logic [2:0] in_color;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_color;
    logic       vga_plot;

    int checks;
    int failures;

    box_drawer #(
        .BOX_WIDTH    (9'd2),
        .BOX_HEIGHT   (9'd2),
        .SCREEN_WIDTH (9'd320),
        .SCREEN_HEIGHT(9'd240),
        .BG_COLOR     (3'b000)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .box_x    (box_x),
        .box_y    (box_y),
        .in_color (in_color),
        .vga_x    (vga_x),
        .vga_y    (vga_y),
        .vga_color(vga_color),
        .vga_plot (vga_plot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Checks one scanned pixel at the current negedge.
    task automatic check_pixel(input string tag, input int px, input int py, input logic [2:0] c);
        check({tag, " rdy"},   32'(m_ready),   32'd0);
        check({tag, " x"},     32'(vga_x),     32'(px & 9'h1FF));
        check({tag, " y"},     32'(vga_y),     32'(py & 8'hFF));
        check({tag, " color"}, 32'(vga_color), 32'(c));
        check({tag, " plot"},  32'(vga_plot),  32'((px < 320 && py < 240) ? 1 : 0));
    endtask

    // Full W*H scan starting in the cycle after the current one.
    task automatic scan(input string tag, input int bx, input int by, input logic [2:0] c);
        for (int r = 0; r < H; r++) begin
            for (int k = 0; k < W; k++) begin
                @(negedge clock);
                check_pixel(tag, bx + k, by + r, c);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clock);
        check({tag, " rdy"},  32'(m_ready),  32'd1);
        check({tag, " plot"}, 32'(vga_plot), 32'd0);
    endtask

    // Called just after a negedge; handshake happens on the next posedge.
    task automatic send(input string tag, input int bx, input int by, input logic [2:0] c);
        check({tag, " accept rdy"}, 32'(m_ready), 32'd1);
        box_x    = 9'(bx);
        box_y    = 9'(by);
        in_color = c;
        m_valid  = 1'b1;
        @(posedge clock);
        #1 m_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        m_valid  = 1'b0;
        box_x    = 9'd0;
        box_y    = 9'd0;
        in_color = 3'd0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset rdy",   32'(m_ready),   32'd1);
        check("reset plot",  32'(vga_plot),  32'd0);
        check("reset x",     32'(vga_x),     32'd0);
        check("reset y",     32'(vga_y),     32'd0);
        check("reset color", 32'(vga_color), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // First frame: no erase regardless of build.
        send("t1", 5, 7, 3'b100);
        scan("t1 draw", 5, 7, 3'b100);
        check_idle("t1 done");

        // Second request, issued on the first idle cycle.
        send("t2", 9, 7, 3'b010);
`ifdef DRAWER_ERASE_EN
        scan("t2 erase", 5, 7, 3'b000);
`endif
        scan("t2 draw", 9, 7, 3'b010);
        check_idle("t2 done");

        // Corner box: only (319,239) is on screen.
        send("t3", 319, 239, 3'b111);
`ifdef DRAWER_ERASE_EN
        scan("t3 erase", 9, 7, 3'b000);
`endif
        scan("t3 draw", 319, 239, 3'b111);
        check_idle("t3 done");

        // m_valid held high; inputs changed mid-scan must not be captured
        // until the single idle cycle between transfers.
        box_x    = 9'd20;
        box_y    = 9'd30;
        in_color = 3'b001;
        m_valid  = 1'b1;
        @(posedge clock);
        #1;
        box_x    = 9'd100;
        box_y    = 9'd100;
        in_color = 3'b101;
`ifdef DRAWER_ERASE_EN
        scan("t4a erase", 319, 239, 3'b000);
`endif
        scan("t4a draw", 20, 30, 3'b001);
        @(negedge clock);
        check("t4 gap rdy", 32'(m_ready), 32'd1);
        @(negedge clock);
        check("t4b rdy low", 32'(m_ready), 32'd0);
        m_valid = 1'b0;
`ifdef DRAWER_ERASE_EN
        check_pixel("t4b erase0", 20, 30, 3'b000);
        for (int i = 1; i < W * H; i++) begin
            @(negedge clock);
            check_pixel("t4b erase", 20 + (i % W), 30 + (i / W), 3'b000);
        end
        scan("t4b draw", 100, 100, 3'b101);
`else
        check_pixel("t4b draw0", 100, 100, 3'b101);
        for (int i = 1; i < W * H; i++) begin
            @(negedge clock);
            check_pixel("t4b draw", 100 + (i % W), 100 + (i / W), 3'b101);
        end
`endif
        check_idle("t4 done");

        // Reset asserted during the second pixel of the draw phase.
        send("t5", 40, 50, 3'b011);
`ifdef DRAWER_ERASE_EN
        scan("t5 erase", 100, 100, 3'b000);
`endif
        @(negedge clock);
        check_pixel("t5 px0", 40, 50, 3'b011);
        @(negedge clock);
        check_pixel("t5 px1", 41, 50, 3'b011);
        reset_n = 1'b0;
        @(negedge clock);
        check("t5 rst rdy",  32'(m_ready),  32'd1);
        check("t5 rst plot", 32'(vga_plot), 32'd0);
        check("t5 rst x",    32'(vga_x),    32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // After reset there is no old box, so this draws without erase.
        send("t6", 60, 70, 3'b110);
        scan("t6 draw", 60, 70, 3'b110);
        check_idle("t6 done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
